// File: rtl/regfile_pkg.sv
// Shared constants and types for the multiport register file.
package regfile_pkg;

    // Default geometry used by the top-level parameters.
    localparam int unsigned DEFAULT_DATA_W   = 32;
    localparam int unsigned DEFAULT_NUM_REGS = 32;
    localparam int unsigned DEFAULT_AW       = $clog2(DEFAULT_NUM_REGS);

    // Register address for the default geometry.
    typedef logic [DEFAULT_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending flags: set on issue, cleared by a completing write or a flush.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_sel,
    input  logic [NUM_REGS-1:0] clear,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Next state: write clears, issue overrides the clear, flush overrides everything.
    always_comb begin
        pending_d = pending_q & ~clear;
        if (issue_en) begin
            pending_d[issue_sel] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        // Register 0 is hardwired and never waits on anything.
        pending_d[0] = 1'b0;
    end

    // Pending flag storage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file with optional write-to-read forwarding and a pending-write scoreboard.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_WR-1:0]        wen,
    input  logic [NUM_WR*AW-1:0]     wsel,
    input  logic [NUM_WR*DATA_W-1:0] wdat,
    input  logic [NUM_RD*AW-1:0]     rsel,
    output logic [NUM_RD*DATA_W-1:0] rdat,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_sel,
    input  logic                     flush
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_data [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    // Resolve write ports per register; ascending loop lets the highest port win.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_data[r] = '0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wen[j] && (wsel[j*AW +: AW] != '0)) begin
                wr_hit[wsel[j*AW +: AW]]  = 1'b1;
                wr_data[wsel[j*AW +: AW]] = wdat[j*DATA_W +: DATA_W];
            end
        end
    end

    // Register storage; entry 0 is only ever reset and is masked on read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_data[r];
                end
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk       (clk),
        .n_rst     (n_rst),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .clear     (wr_hit),
        .flush     (flush),
        .pending   (pending)
    );

    // Combinational read ports with forwarding; forwarding is gated by reset so
    // outputs stay at zero while reset is held.
    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] addr;
            logic          fwd;
            addr = rsel[i*AW +: AW];
            fwd  = (BYPASS != 0) && n_rst && (addr != '0) && wr_hit[addr];
            if (addr == '0) begin
                rdat[i*DATA_W +: DATA_W] = '0;
            end else if (fwd) begin
                rdat[i*DATA_W +: DATA_W] = wr_data[addr];
            end else begin
                rdat[i*DATA_W +: DATA_W] = regs_q[addr];
            end
            rbusy[i] = pending[addr] && !fwd;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench; runs a forwarding and a non-forwarding instance side by side.
module tb_multiport_register_file;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = DEFAULT_AW;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [1:0]    wen;
    logic [2*AW-1:0] wsel;
    logic [2*DW-1:0] wdat;
    logic [2*AW-1:0] rsel;
    logic [2*DW-1:0] rdat, rdat_nb;
    logic [1:0]    rbusy, rbusy_nb;
    logic          issue_en;
    logic [AW-1:0] issue_sel;
    logic          flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiport_register_file #(.BYPASS(1)) dut (
        .clk(clk), .n_rst(n_rst), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
        .issue_en(issue_en), .issue_sel(issue_sel), .flush(flush)
    );

    multiport_register_file #(.BYPASS(0)) dut_nb (
        .clk(clk), .n_rst(n_rst), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat_nb), .rbusy(rbusy_nb),
        .issue_en(issue_en), .issue_sel(issue_sel), .flush(flush)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
        rsel = {a1, a0};
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input reg_addr_t s0, input logic [31:0] d0,
                          input reg_addr_t s1, input logic [31:0] d1);
        wen  = en;
        wsel = {s1, s0};
        wdat = {d1, d0};
    endtask

    initial begin
        n_rst = 1'b0; wen = '0; wsel = '0; wdat = '0; rsel = '0;
        issue_en = 1'b0; issue_sel = '0; flush = 1'b0;
        step(); step();

        // Reset state on every address and both ports.
        for (int a = 0; a < 32; a++) begin
            set_rd(reg_addr_t'(a), reg_addr_t'(31 - a));
            check_val("rst_rdat", rdat, 64'h0);
            check_val("rst_rbusy", {62'h0, rbusy}, 64'h0);
        end
        n_rst = 1'b1;
        step();

        // Forwarding vs. no forwarding, then committed value.
        set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0);
        check_val("byp_same_cycle", rdat[31:0], 64'hDEADBEEF);
        check_val("nobyp_same_cycle", rdat_nb[31:0], 64'h0);
        step();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check_val("byp_next_cycle", rdat[31:0], 64'hDEADBEEF);
        check_val("nobyp_next_cycle", rdat_nb[31:0], 64'hDEADBEEF);

        // Write-port conflict: highest index wins.
        set_wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        set_rd(5'd5, 5'd7);
        check_val("conflict_byp", rdat[63:32], 64'h22);
        step();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check_val("conflict_r7", rdat[63:32], 64'h22);
        check_val("conflict_r7_nb", rdat_nb[63:32], 64'h22);

        // r0 ignores writes.
        set_wr(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0);
        check_val("r0_same", rdat[31:0], 64'h0);
        step();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check_val("r0_after", rdat[31:0], 64'h0);

        // Scoreboard: issue r3, write two cycles later.
        issue_en = 1'b1; issue_sel = 5'd3;
        set_rd(5'd3, 5'd0);
        check_val("busy_issue_cycle", {62'h0, rbusy}, 64'h0);
        step();
        issue_en = 1'b0;
        #1;
        check_val("busy_c1", {62'h0, rbusy}, 64'h1);
        step();
        check_val("busy_c2", {62'h0, rbusy}, 64'h1);
        step();
        set_wr(2'b10, 5'd0, 32'h0, 5'd3, 32'h33);
        #1;
        check_val("busy_write_byp", {62'h0, rbusy}, 64'h0);
        check_val("busy_write_nobyp", {62'h0, rbusy_nb}, 64'h1);
        step();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check_val("busy_after_write", {62'h0, rbusy}, 64'h0);
        check_val("r3_data", rdat[31:0], 64'h33);

        // Issue and write in the same cycle: issue wins.
        issue_en = 1'b1; issue_sel = 5'd3;
        set_wr(2'b01, 5'd3, 32'h44, 5'd0, 32'h0);
        step();
        issue_en = 1'b0;
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check_val("issue_beats_write", {62'h0, rbusy}, 64'h1);
        check_val("issue_write_data", rdat[31:0], 64'h44);

        // Flush overrides a same-cycle issue.
        issue_en = 1'b1;
        issue_sel = 5'd1; step();
        issue_sel = 5'd2; step();
        issue_sel = 5'd4; step();
        issue_en = 1'b0;
        set_rd(5'd1, 5'd4);
        check_val("pend_r1_r4", {62'h0, rbusy}, 64'h3);
        set_rd(5'd2, 5'd6);
        check_val("pend_r2_r6", {62'h0, rbusy}, 64'h1);
        flush = 1'b1; issue_en = 1'b1; issue_sel = 5'd6;
        step();
        flush = 1'b0; issue_en = 1'b0;
        set_rd(5'd1, 5'd2);
        check_val("flush_r1_r2", {62'h0, rbusy}, 64'h0);
        set_rd(5'd4, 5'd6);
        check_val("flush_r4_r6", {62'h0, rbusy}, 64'h0);
        set_rd(5'd3, 5'd7);
        check_val("flush_r3_r7", {62'h0, rbusy}, 64'h0);
        check_val("flush_keeps_data", rdat, {32'h22, 32'h44});

        // Reset asserted mid-write discards the write.
        set_wr(2'b01, 5'd9, 32'hAAAA5555, 5'd0, 32'h0);
        issue_en = 1'b1; issue_sel = 5'd9;
        set_rd(5'd9, 5'd5);
        n_rst = 1'b0;
        #1;
        check_val("rst_mid_rdat", rdat, 64'h0);
        check_val("rst_mid_rbusy", {62'h0, rbusy}, 64'h0);
        step();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        issue_en = 1'b0;
        n_rst = 1'b1;
        #1;
        check_val("rst_r9_r5", rdat, 64'h0);
        check_val("rst_pend", {62'h0, rbusy}, 64'h0);

        // Normal operation resumes after reset.
        set_wr(2'b01, 5'd9, 32'h1234, 5'd0, 32'h0);
        step();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        check_val("resume_r9", rdat_nb[31:0], 64'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
